// File: rtl/fetch_if.sv
// Instruction-memory read bus between fetch and memory.
// Signals: req/addr from fetch, ack/data from memory; master=fetch.
interface fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_data
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_data
  );
endinterface

// File: rtl/fetch.sv
// Multicycle fetch front end: one mem read per instr, waits for next PC.
// Ports: clk, reset (sync, active-low), fetch_en_i, pc_wd_i/pc_valid_i
// from writeback, mem (fetch_if.master: req/addr/ack/data),
// ir_o/pc_o/ir_valid_o/ir_ready_i to decode, fault_o/fault_cause_o,
// fetch_count_o. Optional macro FETCH_TIMEOUT_EN enables REQ timeout.
module fetch #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en_i,
  input  logic [31:0] pc_wd_i,
  input  logic        pc_valid_i,
  fetch_if.master     mem,
  output logic [31:0] ir_o,
  output logic [31:0] pc_o,
  output logic        ir_valid_o,
  input  logic        ir_ready_i,
  output logic        fault_o,
  output logic [1:0]  fault_cause_o,
  output logic [31:0] fetch_count_o
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    HOLD,
    WAITPC,
    FAULT
  } state_e;

  localparam logic [1:0] CAUSE_MIS = 2'b01;
`ifdef FETCH_TIMEOUT_EN
  localparam logic [1:0] CAUSE_TMO = 2'b10;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
`endif

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        valid_q, valid_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic        fault_q, fault_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] cnt_q, cnt_d;
`ifdef FETCH_TIMEOUT_EN
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      fault_q <= 1'b0;
      cause_q <= 2'b00;
      cnt_q   <= '0;
`ifdef FETCH_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      fault_q <= fault_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
`ifdef FETCH_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    valid_d = valid_q;
    req_d   = req_q;
    addr_d  = addr_q;
    fault_d = fault_q;
    cause_d = cause_q;
    cnt_d   = cnt_q;
`ifdef FETCH_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (fetch_en_i) begin
          if (RESET_PC[1:0] != 2'b00) begin
            fault_d = 1'b1;
            cause_d = CAUSE_MIS;
            state_d = FAULT;
          end else begin
            req_d   = 1'b1;
            addr_d  = pc_q;
            state_d = REQ;
`ifdef FETCH_TIMEOUT_EN
            tmo_d   = '0;
`endif
          end
        end
      end
      REQ: begin
        if (mem.mem_ack) begin
          ir_d    = mem.mem_data;
          valid_d = 1'b1;
          req_d   = 1'b0;
          cnt_d   = cnt_q + 32'd1;
          state_d = HOLD;
        end
`ifdef FETCH_TIMEOUT_EN
        // Ack on the limit cycle wins over the timeout.
        else if (tmo_q == TMO_LAST) begin
          req_d   = 1'b0;
          fault_d = 1'b1;
          cause_d = CAUSE_TMO;
          state_d = FAULT;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
`endif
      end
      HOLD: begin
        // pc_valid_i here is dropped; writeback must re-strobe.
        if (ir_ready_i) begin
          valid_d = 1'b0;
          state_d = WAITPC;
        end
      end
      WAITPC: begin
        if (pc_valid_i) begin
          pc_d = pc_wd_i;
          if (pc_wd_i[1:0] == 2'b00) begin
            req_d   = 1'b1;
            addr_d  = pc_wd_i;
            state_d = REQ;
`ifdef FETCH_TIMEOUT_EN
            tmo_d   = '0;
`endif
          end else begin
            fault_d = 1'b1;
            cause_d = CAUSE_MIS;
            state_d = FAULT;
          end
        end
      end
      FAULT: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_addr  = addr_q;
  assign ir_o          = ir_q;
  assign pc_o          = pc_q;
  assign ir_valid_o    = valid_q;
  assign fault_o       = fault_q;
  assign fault_cause_o = cause_q;
  assign fetch_count_o = cnt_q;

endmodule

// File: tb/tb_fetch.sv
// Directed self-checking bench for fetch.
// Second instance uses a misaligned RESET_PC.
module tb_fetch;
  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en_i;
  logic [31:0] pc_wd_i;
  logic        pc_valid_i;
  logic        ir_ready_i;
  logic [31:0] ir_o, pc_o, fetch_count_o;
  logic        ir_valid_o, fault_o;
  logic [1:0]  fault_cause_o;

  logic [31:0] m_ir, m_pc, m_cnt;
  logic        m_valid, m_fault;
  logic [1:0]  m_cause;

  int checks = 0;
  int errors = 0;
  int req_cycles;

  fetch_if mif ();
  fetch_if mif2 ();

  always #5 clk = ~clk;

  fetch #(.RESET_PC(32'h0), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .fetch_en_i(fetch_en_i),
    .pc_wd_i(pc_wd_i), .pc_valid_i(pc_valid_i), .mem(mif),
    .ir_o(ir_o), .pc_o(pc_o), .ir_valid_o(ir_valid_o),
    .ir_ready_i(ir_ready_i), .fault_o(fault_o),
    .fault_cause_o(fault_cause_o), .fetch_count_o(fetch_count_o)
  );

  fetch #(.RESET_PC(32'h2), .TIMEOUT_CYCLES(16)) dut_mis (
    .clk(clk), .reset(reset), .fetch_en_i(fetch_en_i),
    .pc_wd_i(pc_wd_i), .pc_valid_i(pc_valid_i), .mem(mif2),
    .ir_o(m_ir), .pc_o(m_pc), .ir_valid_o(m_valid),
    .ir_ready_i(ir_ready_i), .fault_o(m_fault),
    .fault_cause_o(m_cause), .fetch_count_o(m_cnt)
  );

  assign mif2.mem_ack  = 1'b0;
  assign mif2.mem_data = 32'h0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; fetch_en_i = 1'b0; pc_wd_i = '0; pc_valid_i = 1'b0;
    ir_ready_i = 1'b0; mif.mem_ack = 1'b0; mif.mem_data = '0;
    step(); step();
    chk("rst_req", 32'(mif.mem_req), 0);
    chk("rst_addr", mif.mem_addr, 0);
    chk("rst_pc", pc_o, 0);
    chk("rst_ir", ir_o, 0);
    chk("rst_valid", 32'(ir_valid_o), 0);
    chk("rst_fault", 32'(fault_o), 0);
    chk("rst_cause", 32'(fault_cause_o), 0);
    chk("rst_cnt", fetch_count_o, 0);
    chk("rst_mis_pc", m_pc, 32'h2);

    // First fetch, zero-wait memory
    reset = 1'b1; fetch_en_i = 1'b1;
    step();
    chk("f1_req", 32'(mif.mem_req), 1);
    chk("f1_addr", mif.mem_addr, 0);
    chk("mis_fault", 32'(m_fault), 1);
    chk("mis_cause", 32'(m_cause), 1);
    chk("mis_req", 32'(mif2.mem_req), 0);
    mif.mem_ack = 1'b1; mif.mem_data = 32'h0050_0093;
    step();
    mif.mem_ack = 1'b0;
    chk("f1_ir", ir_o, 32'h0050_0093);
    chk("f1_pc", pc_o, 0);
    chk("f1_valid", 32'(ir_valid_o), 1);
    chk("f1_cnt", fetch_count_o, 1);
    chk("f1_reqlo", 32'(mif.mem_req), 0);

    // HOLD stall; pc_valid_i in HOLD is ignored
    pc_valid_i = 1'b1; pc_wd_i = 32'h4;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_valid", 32'(ir_valid_o), 1);
      chk("hold_ir", ir_o, 32'h0050_0093);
      chk("hold_req", 32'(mif.mem_req), 0);
    end
    pc_valid_i = 1'b0; ir_ready_i = 1'b1;
    step();
    ir_ready_i = 1'b0;
    chk("acc_valid", 32'(ir_valid_o), 0);
    chk("acc_req", 32'(mif.mem_req), 0);
    pc_valid_i = 1'b1; pc_wd_i = 32'h4;
    step();
    pc_valid_i = 1'b0;
    chk("f2_req", 32'(mif.mem_req), 1);
    chk("f2_addr", mif.mem_addr, 32'h4);
    chk("f2_pc", pc_o, 32'h4);

    // Ack three cycles late; pc_valid_i in REQ ignored
    req_cycles = 1;
    fetch_en_i = 1'b0;
    pc_valid_i = 1'b1; pc_wd_i = 32'h40;
    for (int i = 0; i < 3; i++) begin
      step();
      pc_valid_i = 1'b0;
      if (mif.mem_req) req_cycles++;
      chk("late_addr", mif.mem_addr, 32'h4);
      chk("late_pc", pc_o, 32'h4);
    end
    mif.mem_ack = 1'b1; mif.mem_data = 32'h00a0_0113;
    step();
    mif.mem_ack = 1'b0;
    if (mif.mem_req) req_cycles++;
    chk("late_reqcyc", 32'(req_cycles), 4);
    chk("late_ir", ir_o, 32'h00a0_0113);
    chk("late_valid", 32'(ir_valid_o), 1);
    chk("late_cnt", fetch_count_o, 2);

    // Misaligned next PC -> fault
    ir_ready_i = 1'b1;
    step();
    ir_ready_i = 1'b0;
    pc_valid_i = 1'b1; pc_wd_i = 32'h0000_0102;
    step();
    pc_valid_i = 1'b0;
    chk("mpc_fault", 32'(fault_o), 1);
    chk("mpc_cause", 32'(fault_cause_o), 1);
    chk("mpc_pc", pc_o, 32'h102);
    chk("mpc_req", 32'(mif.mem_req), 0);
    fetch_en_i = 1'b1; pc_valid_i = 1'b1; pc_wd_i = 32'h8;
    mif.mem_ack = 1'b1; ir_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("flt_req", 32'(mif.mem_req), 0);
      chk("flt_sticky", 32'(fault_o), 1);
      chk("flt_valid", 32'(ir_valid_o), 0);
    end
    pc_valid_i = 1'b0; mif.mem_ack = 1'b0; ir_ready_i = 1'b0;

    // Reset in the second REQ cycle, then a stray ack
    reset = 1'b0;
    step();
    chk("r2_fault", 32'(fault_o), 0);
    chk("r2_cnt", fetch_count_o, 0);
    reset = 1'b1; fetch_en_i = 1'b1;
    step();
    chk("r2_req1", 32'(mif.mem_req), 1);
    step();
    chk("r2_req2", 32'(mif.mem_req), 1);
    reset = 1'b0;
    step();
    chk("r2_reqdrop", 32'(mif.mem_req), 0);
    chk("r2_pc", pc_o, 0);
    reset = 1'b1; fetch_en_i = 1'b0;
    mif.mem_ack = 1'b1; mif.mem_data = 32'hdead_beef;
    step();
    mif.mem_ack = 1'b0;
    chk("r2_ir", ir_o, 0);
    chk("r2_valid", 32'(ir_valid_o), 0);
    chk("r2_req", 32'(mif.mem_req), 0);
    chk("r2_cnt2", fetch_count_o, 0);

`ifdef FETCH_TIMEOUT_EN
    // No ack: fault at the edge ending the 16th REQ cycle
    fetch_en_i = 1'b1;
    step();
    for (int i = 0; i < 15; i++) begin
      step();
      chk("tmo_wait", 32'(mif.mem_req), 1);
    end
    step();
    chk("tmo_req", 32'(mif.mem_req), 0);
    chk("tmo_fault", 32'(fault_o), 1);
    chk("tmo_cause", 32'(fault_cause_o), 2);
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    for (int i = 0; i < 15; i++) step();
    chk("tmo2_req", 32'(mif.mem_req), 1);
    mif.mem_ack = 1'b1; mif.mem_data = 32'h1234_5678;
    step();
    mif.mem_ack = 1'b0;
    chk("tmo2_ir", ir_o, 32'h1234_5678);
    chk("tmo2_valid", 32'(ir_valid_o), 1);
    chk("tmo2_fault", 32'(fault_o), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
